motor_cmd_sequencer: RTL

Upstream stage of the per-motor PWM generators in the flight-control block. Accepts motor duty commands from the controller over a valid/ready handshake and enforces the arming sequence: throttle-low interlock, arm delay, per-update slew limiting and a command watchdog. It drives the `duty` and `ena` inputs of N PWM generator instances.

---
 rtl/fc_pkg.sv | 20 ++
 rtl/slew_limiter.sv | 50 +++++
 rtl/motor_cmd_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_pkg: shared flight-control types and PWM defaults.  Rev 1.0             |
// +----------------------------------------------------------------------------+
package fc_pkg;

  localparam int SIZE_DEF = 7;
  localparam int BASE_DEF = 100;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAULT    = 2'd3
  } motor_state_e;

  typedef logic [SIZE_DEF-1:0] duty_t;

endpackage
`default_nettype wire

// File: rtl/slew_limiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | slew_limiter: one channel, moves duty toward target by <= SLEW_STEP. Rev 1.0|
// +----------------------------------------------------------------------------+
module slew_limiter #(
  parameter int SIZE      = 7,
  parameter int SLEW_STEP = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            step_en,
  input  logic            zero,
  input  logic [SIZE-1:0] target,
  output logic [SIZE-1:0] duty
);

  logic [SIZE:0] tgt_ext;
  logic [SIZE:0] duty_ext;
  logic [SIZE:0] diff;
  logic [SIZE:0] step_c;
  logic [SIZE:0] duty_nxt;

  // One extra bit keeps the difference and the stepped value from wrapping.
  always_comb begin
    tgt_ext  = {1'b0, target};
    duty_ext = {1'b0, duty};
    step_c   = (SIZE+1)'(SLEW_STEP);
    diff     = '0;
    duty_nxt = duty_ext;
    if (tgt_ext > duty_ext) begin
      diff     = tgt_ext - duty_ext;
      duty_nxt = (diff > step_c) ? duty_ext + step_c : tgt_ext;
    end else begin
      diff     = duty_ext - tgt_ext;
      duty_nxt = (diff > step_c) ? duty_ext - step_c : tgt_ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty <= '0;
    end else if (zero) begin
      duty <= '0;
    end else if (step_en) begin
      duty <= duty_nxt[SIZE-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_cmd_sequencer: arm interlock, slew and watchdog ahead of PWM. Rev 1.0|
// +----------------------------------------------------------------------------+
module motor_cmd_sequencer
  import fc_pkg::*;
#(
  parameter int N_MOTORS    = 4,
  parameter int SIZE        = SIZE_DEF,
  parameter int BASE        = BASE_DEF,
  parameter int UPDATE_DIV  = 1000,
  parameter int SLEW_STEP   = 2,
  parameter int ARM_STROBES = 50,
  parameter int WDT_CYCLES  = 200000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [N_MOTORS*SIZE-1:0] cmd_duty_i,
  input  logic                     arm_req_i,
  input  logic                     disarm_i,
  output logic [N_MOTORS*SIZE-1:0] duty_o,
  output logic                     ena_o,
  output logic [1:0]               state_o,
  output logic                     fault_o
);

  localparam int PW = $clog2(UPDATE_DIV);
  localparam int AW = $clog2(ARM_STROBES + 1);
  localparam int WW = $clog2(WDT_CYCLES + 1);

  motor_state_e             state;
  logic [PW-1:0]            pre_cnt;
  logic [AW-1:0]            arm_cnt;
  logic [WW-1:0]            wdt_cnt;
  logic [N_MOTORS*SIZE-1:0] target;
  logic [N_MOTORS*SIZE-1:0] cmd_clamped;

  logic strobe;
  logic xfer;
  logic cmd_nonzero;
  logic targets_zero;
  logic duties_zero;
  logic wdt_expire;
  logic step_en;
  logic zero;

  assign strobe       = (pre_cnt == PW'(UPDATE_DIV - 1));
  assign cmd_ready_o  = (state != ST_FAULT);
  assign xfer         = cmd_valid_i && cmd_ready_o;
  assign cmd_nonzero  = |cmd_duty_i;
  assign targets_zero = ~|target;
  assign duties_zero  = ~|duty_o;
  // A transfer on the expiry cycle wins over the watchdog.
  assign wdt_expire   = (state == ST_ARMED) && !xfer && (wdt_cnt == WW'(WDT_CYCLES - 1));
  assign step_en      = strobe && ((state == ST_ARMED) || (state == ST_FAULT));
  assign zero         = disarm_i || (state == ST_DISARMED) || (state == ST_ARMING);
  assign state_o      = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_cnt <= '0;
    end else if (strobe) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target <= '0;
    end else if (disarm_i || (state == ST_FAULT) || wdt_expire) begin
      target <= '0;
    end else if (xfer) begin
      target <= cmd_clamped;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_DISARMED;
      ena_o   <= 1'b0;
      fault_o <= 1'b0;
      arm_cnt <= '0;
      wdt_cnt <= '0;
    end else if (disarm_i) begin
      state   <= ST_DISARMED;
      ena_o   <= 1'b0;
      arm_cnt <= '0;
      wdt_cnt <= '0;
    end else begin
      case (state)
        ST_DISARMED: begin
          arm_cnt <= '0;
          wdt_cnt <= '0;
          if (arm_req_i && targets_zero) begin
            state   <= ST_ARMING;
            ena_o   <= 1'b1;
            fault_o <= 1'b0;
          end
        end
        ST_ARMING: begin
          if (xfer && cmd_nonzero) begin
            state   <= ST_DISARMED;
            ena_o   <= 1'b0;
            arm_cnt <= '0;
          end else if (strobe) begin
            if (arm_cnt == AW'(ARM_STROBES - 1)) begin
              state   <= ST_ARMED;
              arm_cnt <= '0;
              wdt_cnt <= '0;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (xfer) begin
            wdt_cnt <= '0;
          end else if (wdt_expire) begin
            state   <= ST_FAULT;
            fault_o <= 1'b1;
            wdt_cnt <= '0;
          end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          if (duties_zero) begin
            state <= ST_DISARMED;
            ena_o <= 1'b0;
          end
        end
        default: begin
          state <= ST_DISARMED;
          ena_o <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_MOTORS; k++) begin : g_ch
    assign cmd_clamped[k*SIZE +: SIZE] =
      (cmd_duty_i[k*SIZE +: SIZE] > SIZE'(BASE)) ? SIZE'(BASE) : cmd_duty_i[k*SIZE +: SIZE];

    slew_limiter #(
      .SIZE      (SIZE),
      .SLEW_STEP (SLEW_STEP)
    ) u_slew (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .step_en (step_en),
      .zero    (zero),
      .target  (target[k*SIZE +: SIZE]),
      .duty    (duty_o[k*SIZE +: SIZE])
    );
  end

endmodule
`default_nettype wire
